pulse_mux_sched: RTL and testbench

PULSE_MUX_SCHED -- requirements
Module: pulse_mux_sched

---
 rtl/pulse_mux_sched_pkg.sv | 19 +
 rtl/pulse_mux_sched_rr_arb.sv | 38 +++
 rtl/pulse_mux_sched.sv | 166 ++++++++++++++++
 tb/tb_pulse_mux_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_mux_sched_pkg.sv
// pulse_mux_pkg
// Shared definitions for the pulse_mux_sched block: scheduler FSM state
// type, default parameter values and the gap counter width.
// No ports (package only).
package pulse_mux_pkg;

  localparam int NREQ_DEFAULT  = 4;
  localparam int CNT_W_DEFAULT = 3;
  localparam int GAP_DEFAULT   = 4;

  // GAP may be as large as 255, so the gap counter is always 8 bits wide.
  localparam int GAP_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/pulse_mux_sched_rr_arb.sv
// rr_arb
// Purely combinational round-robin picker. The search begins one index
// past the last grant and wraps from NREQ-1 back to 0.
// Ports:
//   req       - one bit per requester with work pending
//   last      - index granted most recently
//   grant     - index of the chosen requester (0 when nothing is pending)
//   grant_vld - high when some requester was chosen
module rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] grant,
  output logic                    grant_vld
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] idx;

  // Walk the requesters starting just after the last grant. The first one
  // with work pending wins. A full lap (k = NREQ) revisits 'last' itself,
  // so a lone requester can win again and again.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

endmodule

// File: rtl/pulse_mux_sched.sv
// pulse_mux_sched
// Lets several requesters share one pulse-sync channel. Each requester has
// a saturating pending counter. A round-robin scheduler sends out one
// registered pulse at a time, and pulses are spaced at least GAP clocks
// apart so the downstream toggle synchronizer is never overrun.
// Ports:
//   clk       - single clock, rising edge
//   rstn      - asynchronous active-low reset
//   req_pulse - single-cycle event pulses, one per requester
//   out_pulse - registered single-cycle issue pulse
//   out_id    - requester index of the latest issue, held until the next
//   busy      - any counter nonzero or scheduler in HOLD
//   ovf       - sticky per-requester overflow flags
//   clr_ovf   - synchronous clear of all ovf bits
// Configuration macro: PULSE_MUX_SCHED_OVF_EN enables overflow tracking.
// When the macro is undefined, ovf reads 0 and clr_ovf is ignored.
module pulse_mux_sched
  import pulse_mux_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int GAP   = GAP_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_pulse,
  output logic                    out_pulse,
  output logic [$clog2(NREQ)-1:0] out_id,
  output logic                    busy,
  output logic [NREQ-1:0]         ovf,
  input  logic                    clr_ovf
);

  localparam int                IDW      = $clog2(NREQ);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP);

  logic [CNT_W-1:0] cnt [NREQ];
  logic [NREQ-1:0]  pend;
  logic [NREQ-1:0]  dec;
  logic [NREQ-1:0]  drop;
  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [IDW-1:0]   last_ptr;
  logic [IDW-1:0]   win;
  logic             win_vld;
  logic             issue;

  // A requester has work pending while its counter is nonzero. 'dec' marks
  // the counter being served this cycle. 'drop' marks a request that hits a
  // full counter and is not offset by a same-cycle issue.
  always_comb begin
    pend = '0;
    dec  = '0;
    drop = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = (cnt[i] != '0);
      dec[i]  = issue && (win == IDW'(i));
      drop[i] = req_pulse[i] && !dec[i] && (cnt[i] == CNT_MAX);
    end
  end

  rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .req       (pend),
    .last      (last_ptr),
    .grant     (win),
    .grant_vld (win_vld)
  );

  // Scheduler: IDLE issues as soon as something is pending. HOLD counts the
  // gap down and, on its final cycle, either issues again back-to-back or
  // falls back to IDLE. Issuing at gap==1 gives exactly GAP cycles between
  // pulses.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        gap_nxt = '0;
        if (win_vld) begin
          issue     = 1'b1;
          state_nxt = HOLD;
          gap_nxt   = GAP_LOAD;
        end
      end
      HOLD: begin
        if (gap_cnt <= GAP_W'(1)) begin
          if (win_vld) begin
            issue   = 1'b1;
            gap_nxt = GAP_LOAD;
          end else begin
            state_nxt = IDLE;
            gap_nxt   = '0;
          end
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gap_nxt   = '0;
      end
    endcase
  end

  // State, gap timer, the issue pulse and the round-robin pointer. The
  // pointer resets to NREQ-1 so that requester 0 is searched first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      out_pulse <= 1'b0;
      out_id    <= '0;
      last_ptr  <= IDW'(NREQ - 1);
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_nxt;
      out_pulse <= issue;
      if (issue) begin
        out_id   <= win;
        last_ptr <= win;
      end
    end
  end

  // Pending counters. An arrival and a service in the same cycle cancel
  // out. An arrival at a full counter is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_pulse[i] && !dec[i]) begin
          if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
        end else if (!req_pulse[i] && dec[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  assign busy = (|pend) || (state == HOLD);

`ifdef PULSE_MUX_SCHED_OVF_EN
  logic [NREQ-1:0] ovf_q;

  // Sticky overflow flags. OR-ing in new drops after the clear means a drop
  // in the same cycle as clr_ovf keeps its flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (clr_ovf ? '0 : ovf_q) | drop;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_inputs;

  assign unused_ovf_inputs = clr_ovf | (|drop);
  assign ovf               = '0;
`endif

endmodule

// File: tb/tb_pulse_mux_sched.sv
// tb_pulse_mux_sched
// Directed self-checking bench for pulse_mux_sched (NREQ=4, CNT_W=3, GAP=4).
// Cycle k is the clock period after rising edge k. Inputs are driven and
// outputs sampled 1 ns after each rising edge.
module tb_pulse_mux_sched;

  logic       clk;
  logic       rstn;
  logic [3:0] req_pulse;
  logic       out_pulse;
  logic [1:0] out_id;
  logic       busy;
  logic [3:0] ovf;
  logic       clr_ovf;

  int total;
  int bad;

`ifdef PULSE_MUX_SCHED_OVF_EN
  localparam logic [3:0] OVF_EXP = 4'b0010;
`else
  localparam logic [3:0] OVF_EXP = 4'b0000;
`endif

  pulse_mux_sched #(.NREQ(4), .CNT_W(3), .GAP(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_pulse (req_pulse),
    .out_pulse (out_pulse),
    .out_id    (out_id),
    .busy      (busy),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges and release it away from the clock edge.
  task automatic do_reset;
    req_pulse = '0;
    clr_ovf   = 1'b0;
    rstn      = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // Async reset takes effect with no clock edge.
  task automatic test_reset;
    req_pulse = '0;
    clr_ovf   = 1'b0;
    rstn      = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    total++; if (out_pulse !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_pulse got=%0h want=0", out_pulse); end
    total++; if (out_id !== 2'd0) begin bad++; $display("[TB] FAIL reset_out_id got=%0h want=0", out_id); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0h want=0", busy); end
    total++; if (ovf !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ovf got=%0h want=0", ovf); end
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // One request on requester 2. Expect a pulse in cycle 2 and busy low from cycle 6.
  task automatic test_single;
    logic exp_p;
    logic exp_b;
    do_reset();
    req_pulse = 4'b0100;
    for (int c = 0; c <= 9; c++) begin
      exp_p = (c == 2);
      exp_b = (c >= 1 && c <= 5);
      total++; if (out_pulse !== exp_p) begin bad++; $display("[TB] FAIL single_pulse c=%0d got=%0h want=%0h", c, out_pulse, exp_p); end
      total++; if (busy !== exp_b) begin bad++; $display("[TB] FAIL single_busy c=%0d got=%0h want=%0h", c, busy, exp_b); end
      if (c == 2) begin
        total++; if (out_id !== 2'd2) begin bad++; $display("[TB] FAIL single_id got=%0d want=2", out_id); end
      end
      tick();
      req_pulse = '0;
    end
  endtask

  // All four requesters at once. Pulses in cycles 2, 6, 10, 14 with ids 0..3.
  task automatic test_all_four;
    logic       exp_p;
    logic [1:0] exp_id;
    do_reset();
    req_pulse = 4'b1111;
    for (int c = 0; c <= 19; c++) begin
      exp_p = (c >= 2 && c <= 14 && ((c - 2) % 4) == 0);
      total++; if (out_pulse !== exp_p) begin bad++; $display("[TB] FAIL all4_pulse c=%0d got=%0h want=%0h", c, out_pulse, exp_p); end
      if (exp_p) begin
        exp_id = 2'((c - 2) / 4);
        total++; if (out_id !== exp_id) begin bad++; $display("[TB] FAIL all4_id c=%0d got=%0d want=%0d", c, out_id, exp_id); end
      end
      if (c == 17) begin
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL all4_busy_hold got=%0h want=1", busy); end
      end
      if (c == 18) begin
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL all4_busy_done got=%0h want=0", busy); end
      end
      tick();
      req_pulse = '0;
    end
  endtask

  // Requester 1 pulses in cycles 0..11. Ten requests are accepted and two are
  // dropped. clr_ovf in cycle 11 collides with a new drop, so the flag stays
  // set. clr_ovf in cycle 12 then clears it.
  task automatic test_saturate;
    logic       exp_p;
    logic [3:0] exp_ovf;
    int         npulse;
    do_reset();
    npulse = 0;
    for (int c = 0; c <= 45; c++) begin
      req_pulse = (c <= 11) ? 4'b0010 : 4'b0000;
      clr_ovf   = (c == 11 || c == 12);
      exp_p     = (c >= 2 && c <= 38 && ((c - 2) % 4) == 0);
      exp_ovf   = (c == 11 || c == 12) ? OVF_EXP : 4'b0000;
      total++; if (out_pulse !== exp_p) begin bad++; $display("[TB] FAIL sat_pulse c=%0d got=%0h want=%0h", c, out_pulse, exp_p); end
      total++; if (ovf !== exp_ovf) begin bad++; $display("[TB] FAIL sat_ovf c=%0d got=%0h want=%0h", c, ovf, exp_ovf); end
      if (out_pulse === 1'b1) begin
        npulse++;
        total++; if (out_id !== 2'd1) begin bad++; $display("[TB] FAIL sat_id c=%0d got=%0d want=1", c, out_id); end
      end
      if (c == 41) begin
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL sat_busy_hold got=%0h want=1", busy); end
      end
      if (c == 42) begin
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL sat_busy_done got=%0h want=0", busy); end
      end
      tick();
    end
    req_pulse = '0;
    clr_ovf   = 1'b0;
    total++; if (npulse != 10) begin bad++; $display("[TB] FAIL sat_count got=%0d want=10", npulse); end
  endtask

  // Requesters 0 and 3 pulse every cycle. Ids alternate 0, 3, 0, 3, ... 4 cycles apart.
  task automatic test_alternate;
    logic       exp_p;
    logic [1:0] exp_id;
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      req_pulse = (c <= 20) ? 4'b1001 : 4'b0000;
      exp_p     = (c >= 2 && ((c - 2) % 4) == 0);
      total++; if (out_pulse !== exp_p) begin bad++; $display("[TB] FAIL alt_pulse c=%0d got=%0h want=%0h", c, out_pulse, exp_p); end
      if (exp_p) begin
        exp_id = (((c - 2) / 4) % 2 == 0) ? 2'd0 : 2'd3;
        total++; if (out_id !== exp_id) begin bad++; $display("[TB] FAIL alt_id c=%0d got=%0d want=%0d", c, out_id, exp_id); end
      end
      tick();
    end
    req_pulse = '0;
  endtask

  // A second request arrives near the end of the gap. When it is already
  // pending on the gap's last cycle (v=0), it goes back-to-back in cycle 6.
  // One cycle later (v=1), the scheduler drops to IDLE first, so the pulse
  // comes in cycle 7.
  task automatic test_back_to_back;
    logic exp_p;
    for (int v = 0; v <= 1; v++) begin
      do_reset();
      for (int c = 0; c <= 12; c++) begin
        req_pulse = (c == 0) ? 4'b0100 : ((c == 4 + v) ? 4'b0010 : 4'b0000);
        exp_p     = (c == 2) || (c == 6 + v);
        total++; if (out_pulse !== exp_p) begin bad++; $display("[TB] FAIL b2b_pulse v=%0d c=%0d got=%0h want=%0h", v, c, out_pulse, exp_p); end
        if (c == 2) begin
          total++; if (out_id !== 2'd2) begin bad++; $display("[TB] FAIL b2b_id_first v=%0d got=%0d want=2", v, out_id); end
        end
        if (c == 6 + v) begin
          total++; if (out_id !== 2'd1) begin bad++; $display("[TB] FAIL b2b_id_second v=%0d got=%0d want=1", v, out_id); end
        end
        if (c == 9 + v) begin
          total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy_hold v=%0d got=%0h want=1", v, busy); end
        end
        if (c == 10 + v) begin
          total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_busy_done v=%0d got=%0h want=0", v, busy); end
        end
        tick();
      end
      req_pulse = '0;
    end
  endtask

  // Reset in the middle of HOLD with 3 events still pending. The pending
  // events are discarded. A fresh request on requester 3 then issues 2 cycles
  // after it arrives.
  task automatic test_reset_mid_hold;
    logic exp_p;
    do_reset();
    req_pulse = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      tick();
      req_pulse = '0;
    end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midrst_busy_before got=%0h want=1", busy); end
    #2;
    rstn = 1'b0;
    #1;
    total++; if (out_pulse !== 1'b0) begin bad++; $display("[TB] FAIL midrst_pulse got=%0h want=0", out_pulse); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%0h want=0", busy); end
    total++; if (ovf !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_ovf got=%0h want=0", ovf); end
    total++; if (out_id !== 2'd0) begin bad++; $display("[TB] FAIL midrst_id got=%0d want=0", out_id); end
    tick();
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++; if (out_pulse !== 1'b0) begin bad++; $display("[TB] FAIL midrst_discard c=%0d got=%0h want=0", c, out_pulse); end
    end
    req_pulse = 4'b1000;
    for (int c = 0; c <= 4; c++) begin
      exp_p = (c == 2);
      total++; if (out_pulse !== exp_p) begin bad++; $display("[TB] FAIL midrst_after_pulse c=%0d got=%0h want=%0h", c, out_pulse, exp_p); end
      if (c == 2) begin
        total++; if (out_id !== 2'd3) begin bad++; $display("[TB] FAIL midrst_after_id got=%0d want=3", out_id); end
      end
      tick();
      req_pulse = '0;
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rstn      = 1'b1;
    req_pulse = '0;
    clr_ovf   = 1'b0;
    $display("[TB] starting pulse_mux_sched bench");
    test_reset();
    test_single();
    test_all_four();
    test_saturate();
    test_alternate();
    test_back_to_back();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
